// File: rtl/cg_pipe_chain.sv
// cg_pipe_chain: valid/ready pipeline with per-stage clock-gated data registers,
// a combinational ready chain that collapses bubbles, and a saturating idle detector.
module clock_gating_cell (
    input  logic clk,
    input  logic enable,
    input  logic scan_enable,
    output logic gclk
);
    logic en_l;
    // Enable is captured while clk is low so gclk never glitches.
    always_latch if (!clk) en_l <= enable | scan_enable;
    assign gclk = clk & en_l;
endmodule

module cg_pipe_chain #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 3,
    parameter int IDLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_enable,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_clk_en,
    output logic             idle
);
    localparam int CW = $clog2(IDLE_CYCLES + 1);
    logic [DEPTH-1:0]            v, load, gclk;
    logic [DEPTH:0]              rdy;
    logic [DEPTH:0][WIDTH-1:0]   pd;
    logic [CW-1:0]               cnt;
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) rdy[i] = !v[i] | rdy[i+1];
        load[0] = in_valid & !flush & rdy[0];
        for (int i = 1; i < DEPTH; i++) load[i] = v[i-1] & rdy[i];
    end
    assign stage_clk_en = load | {DEPTH{scan_enable}};
    assign pd[0]        = in_data;
    assign in_ready     = rdy[0] & !flush;
    assign out_valid    = v[DEPTH-1] & !flush;
    assign out_data     = pd[DEPTH];
    assign idle         = cnt == CW'(IDLE_CYCLES);
    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] q;
        clock_gating_cell u_cg (
            .clk         (clk),
            .enable      (stage_clk_en[g]),
            .scan_enable (scan_enable),
            .gclk        (gclk[g])
        );
        // Flush leaves payload untouched; only the valid bits are cleared.
        always_ff @(posedge gclk[g] or negedge rst_n)
            if (!rst_n) q <= '0;
            else if (load[g] && !flush) q <= pd[g];
        assign pd[g+1] = q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) v <= '0;
        else v <= ~{DEPTH{flush}} & (load | (v & ~rdy[DEPTH:1]));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (in_valid || |v) cnt <= '0;
        else if (!idle) cnt <= cnt + 1'b1;
endmodule
